// File: rtl/viterbi_pkg.sv
// viterbi_pkg: trellis constants, state types and helper functions for the K=3 rate-1/2 Viterbi decoder.
package viterbi_pkg;

    localparam logic [2:0] G1 = 3'b111;
    localparam logic [2:0] G0 = 3'b101;

    typedef logic [1:0] state_t;

    typedef enum logic [1:0] {
        ACS  = 2'd0,
        TB   = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Taps are ordered {input bit, PS[1], PS[0]} so the generators apply directly.
    function automatic logic [1:0] exp_sym(input state_t ps, input logic b);
        logic [2:0] taps;
        taps = {b, ps};
        return {^(taps & G1), ^(taps & G0)};
    endfunction

    function automatic state_t next_state(input state_t ps, input logic b);
        return {b, ps[1]};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// viterbi_acs_unit: add-compare-select for one next-state; saturating adds, ties resolve to the PS[0]=0 candidate.
module viterbi_acs_unit #(
    parameter int PM_W = 7
) (
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [1:0]      bm_a,
    input  logic [1:0]      bm_b,
    output logic [PM_W-1:0] pm_new,
    output logic            dec
);

    logic [PM_W:0]   sum_a;
    logic [PM_W:0]   sum_b;
    logic [PM_W-1:0] sat_a;
    logic [PM_W-1:0] sat_b;

    always_comb begin
        sum_a  = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
        sum_b  = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};
        sat_a  = sum_a[PM_W] ? '1 : sum_a[PM_W-1:0];
        sat_b  = sum_b[PM_W] ? '1 : sum_b[PM_W-1:0];
        dec    = (sat_b < sat_a);
        pm_new = dec ? sat_b : sat_a;
    end

endmodule

// File: rtl/viterbi_decoder_k3.sv
// viterbi_decoder_k3: hard-decision K=3 Viterbi decoder, frame-based traceback with parallel output.
// Build option VITERBI_ZERO_TB_EN: terminated trellis, traceback always starts from state 00.
//  state | meaning
//  ACS   | accept symbols, update path metrics and survivor rows
//  TB    | trace back one trellis step per cycle
//  DONE  | present decoded frame for one cycle, reinitialise metrics
module viterbi_decoder_k3
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 11,
    parameter int PM_W      = 7
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [1:0]           Sym_In,
    input  logic                 Sym_Valid,
    output logic                 Sym_Ready,
    output logic [FRAME_LEN-1:0] Dec_Out,
    output logic                 Dec_Valid,
    output logic [PM_W-1:0]      Err_Metric,
    output logic                 Busy
);

    localparam int              CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [PM_W-1:0] PM_INIT  = {2'b01, {(PM_W-2){1'b0}}};

    fsm_t                 state;
    fsm_t                 state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [PM_W-1:0]      pm      [4];
    logic [PM_W-1:0]      pm_new  [4];
    logic [3:0]           dec_bits;
    logic [3:0]           surv    [FRAME_LEN];
    logic [1:0]           bm_tab  [4][2];
    logic                 xfer;
    state_t               tb_state;
    state_t               start_state;
    state_t               s_cur;
    logic [FRAME_LEN-1:0] tb_bits;
    logic [FRAME_LEN-1:0] tb_bits_nxt;

    assign Sym_Ready = (state == ACS) & ~Rst;
    assign Busy      = (state == TB) | (state == DONE);
    assign xfer      = Sym_Valid & Sym_Ready;

    always_comb begin
        for (int ps = 0; ps < 4; ps++) begin
            for (int b = 0; b < 2; b++) begin
                bm_tab[ps][b] = hamming2(Sym_In, exp_sym(state_t'(ps), b[0]));
            end
        end
    end

    // Next-state g = {b, p1}; predecessors are {p1, 0} and {p1, 1}.
    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam int P1 = g % 2;
        localparam int B  = g / 2;
        viterbi_acs_unit #(
            .PM_W (PM_W)
        ) u_acs (
            .pm_a   (pm[2*P1]),
            .pm_b   (pm[2*P1+1]),
            .bm_a   (bm_tab[2*P1][B]),
            .bm_b   (bm_tab[2*P1+1][B]),
            .pm_new (pm_new[g]),
            .dec    (dec_bits[g])
        );
    end

`ifdef VITERBI_ZERO_TB_EN
    assign start_state = 2'b00;
`else
    always_comb begin
        start_state = 2'b00;
        for (int i = 1; i < 4; i++) begin
            if (pm[i] < pm[start_state]) begin
                start_state = state_t'(i);
            end
        end
    end
`endif

    always_comb begin
        s_cur            = (cnt == CNT_LAST) ? start_state : tb_state;
        tb_bits_nxt      = tb_bits;
        tb_bits_nxt[cnt] = s_cur[1];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACS:     if (xfer && (cnt == CNT_LAST)) state_nxt = TB;
            TB:      if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = ACS;
            default: state_nxt = ACS;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= ACS;
            cnt        <= '0;
            pm[0]      <= '0;
            for (int i = 1; i < 4; i++) pm[i] <= PM_INIT;
            tb_state   <= 2'b00;
            tb_bits    <= '0;
            Dec_Out    <= '0;
            Err_Metric <= '0;
            Dec_Valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            Dec_Valid <= 1'b0;
            case (state)
                ACS: begin
                    if (xfer) begin
                        for (int i = 0; i < 4; i++) pm[i] <= pm_new[i];
                        // Counter parks on the last index so traceback can count down from it.
                        if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                    end
                end
                TB: begin
                    tb_bits  <= tb_bits_nxt;
                    tb_state <= {s_cur[0], surv[cnt][s_cur]};
                    if (cnt == '0) begin
                        Dec_Out    <= tb_bits_nxt;
                        Err_Metric <= pm[start_state];
                        Dec_Valid  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    pm[0] <= '0;
                    for (int i = 1; i < 4; i++) pm[i] <= PM_INIT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (xfer) surv[cnt] <= dec_bits;
    end

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// tb_viterbi_decoder_k3: scoreboard bench; a reference encoder builds frames and expected decodes are queued.
module tb_viterbi_decoder_k3;

    localparam int FRAME_LEN = 11;
    localparam int PM_W      = 7;

    typedef struct {
        logic [FRAME_LEN-1:0] dec;
        logic [PM_W-1:0]      err;
        bit                   err_nonzero_only;
    } exp_t;

    logic                 Clk;
    logic                 Rst;
    logic [1:0]           Sym_In;
    logic                 Sym_Valid;
    logic                 Sym_Ready;
    logic [FRAME_LEN-1:0] Dec_Out;
    logic                 Dec_Valid;
    logic [PM_W-1:0]      Err_Metric;
    logic                 Busy;

    logic [1:0] syms [FRAME_LEN];
    exp_t       sb_q [$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_pass   = 0;

    viterbi_decoder_k3 #(
        .FRAME_LEN (FRAME_LEN),
        .PM_W      (PM_W)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Sym_In     (Sym_In),
        .Sym_Valid  (Sym_Valid),
        .Sym_Ready  (Sym_Ready),
        .Dec_Out    (Dec_Out),
        .Dec_Valid  (Dec_Valid),
        .Err_Metric (Err_Metric),
        .Busy       (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference encoder: PS = {x[k-1], x[k-2]}, starts in 00.
    task automatic encode_frame(input logic [FRAME_LEN-1:0] d);
        logic [1:0] ps;
        logic       x;
        ps = 2'b00;
        for (int k = 0; k < FRAME_LEN; k++) begin
            x       = d[k];
            syms[k] = {x ^ ps[1] ^ ps[0], x ^ ps[0]};
            ps      = {x, ps[1]};
        end
    endtask

    task automatic push_exp(input logic [FRAME_LEN-1:0] dec, input logic [PM_W-1:0] err,
                            input bit nz_only);
        exp_t e;
        e.dec = dec;
        e.err = err;
        e.err_nonzero_only = nz_only;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge following the last accepting edge.
    task automatic send_syms(input int n_sym, input bit hold_valid);
        for (int i = 0; i < n_sym; i++) begin
            int wait_cnt;
            wait_cnt  = 0;
            Sym_In    = syms[i];
            Sym_Valid = 1'b1;
            while (!Sym_Ready && wait_cnt < 50) begin
                @(negedge Clk);
                wait_cnt++;
            end
            if (wait_cnt >= 50) chk_eq("ready_timeout", 0, 1);
            @(negedge Clk);
        end
        if (hold_valid) Sym_In = 2'b11;
        else Sym_Valid = 1'b0;
    endtask

    task automatic post_frame(input logic [FRAME_LEN-1:0] dec, input bit nz_only);
        int lat;
        int rdy_low;
        lat     = 0;
        rdy_low = 0;
        for (int k = 1; k <= 40; k++) begin
            if (Dec_Valid && lat == 0) lat = k;
            if (Sym_Ready) break;
            if (k == 1) chk_eq("busy_in_tb", Busy, 1);
            rdy_low++;
            @(negedge Clk);
        end
        Sym_Valid = 1'b0;
        chk_eq("dec_valid_latency", lat, 12);
        chk_eq("ready_low_cycles", rdy_low, 12);
        chk_eq("dec_valid_one_cycle", Dec_Valid, 0);
        chk_eq("busy_idle", Busy, 0);
        if (!nz_only) chk_eq("dec_out_hold", Dec_Out, dec);
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clk);
        Rst       = 1'b1;
        Sym_Valid = 1'b0;
        @(negedge Clk);
        chk_eq({tag, "_sym_ready"}, Sym_Ready, 0);
        chk_eq({tag, "_dec_valid"}, Dec_Valid, 0);
        chk_eq({tag, "_dec_out"}, Dec_Out, 0);
        chk_eq({tag, "_err_metric"}, Err_Metric, 0);
        chk_eq({tag, "_busy"}, Busy, 0);
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic run_frame(input logic [FRAME_LEN-1:0] d, input bit hold_valid);
        encode_frame(d);
        push_exp(d, '0, 1'b0);
        send_syms(FRAME_LEN, hold_valid);
        post_frame(d, 1'b0);
    endtask

    always @(negedge Clk) begin
        if (Dec_Valid) begin
            if (sb_q.size() == 0) begin
                chk_eq("spurious_dec_valid", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.err_nonzero_only) begin
                    chk_eq("err_metric_nonzero", (Err_Metric != 0), 1);
                end else begin
                    chk_eq("dec_out", Dec_Out, mon_e.dec);
                    chk_eq("err_metric", Err_Metric, mon_e.err);
                end
            end
        end
    end

    initial begin
        Rst       = 1'b1;
        Sym_Valid = 1'b0;
        Sym_In    = 2'b00;
        repeat (2) @(negedge Clk);
        chk_eq("rst_sym_ready", Sym_Ready, 0);
        chk_eq("rst_dec_valid", Dec_Valid, 0);
        chk_eq("rst_dec_out", Dec_Out, 0);
        chk_eq("rst_err_metric", Err_Metric, 0);
        chk_eq("rst_busy", Busy, 0);
        Rst = 1'b0;
        @(negedge Clk);
        chk_eq("idle_sym_ready", Sym_Ready, 1);

        run_frame(11'h000, 1'b0);
        run_frame(11'h00D, 1'b0);

        // Single channel error in symbol 2 (00 -> 10).
        encode_frame(11'h00D);
        syms[2] = syms[2] ^ 2'b10;
        push_exp(11'h00D, 7'd1, 1'b0);
        send_syms(FRAME_LEN, 1'b0);
        post_frame(11'h00D, 1'b0);

        // Valid held high through traceback, then a fresh random frame.
        run_frame(11'h00D, 1'b1);
        for (int f = 0; f < 3; f++) begin
            logic [FRAME_LEN-1:0] d;
            d = FRAME_LEN'($urandom_range(0, 511));
            run_frame(d, 1'b0);
        end

        // Reset after five symbols: nothing decoded, next frame clean.
        encode_frame(11'h00D);
        send_syms(5, 1'b0);
        do_reset("rst_mid_frame");
        repeat (20) @(negedge Clk);
        run_frame(11'h00D, 1'b0);

        // Reset while tracing back.
        encode_frame(11'h0A5);
        send_syms(FRAME_LEN, 1'b0);
        repeat (4) @(negedge Clk);
        chk_eq("busy_before_tb_reset", Busy, 1);
        do_reset("rst_mid_tb");
        repeat (20) @(negedge Clk);
        run_frame(11'h00D, 1'b0);

        // Unterminated all-ones frame.
        encode_frame(11'h7FF);
`ifdef VITERBI_ZERO_TB_EN
        push_exp(11'h000, '0, 1'b1);
        send_syms(FRAME_LEN, 1'b0);
        post_frame(11'h000, 1'b1);
`else
        push_exp(11'h7FF, '0, 1'b0);
        send_syms(FRAME_LEN, 1'b0);
        post_frame(11'h7FF, 1'b0);
`endif

        for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge Clk);
        chk_eq("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
